branch_program_counter: RTL
===========================

# branch_program_counter

Parametrised program counter for the 6502 core: byte-split PC with load, increment, and a two-phase relative-branch adder that mirrors the 6502 page-cross penalty. The low byte is adjusted first; if the signed offset carries or borrows out of the low byte, the high part is fixed up one cycle later. It sits between the instruction sequencer (control strobes) and the address bus mux (PCL_out/PCH_out), and replaces the fixed 16-bit load/increment counter.

## Interface
- ADDR_W, 16: total PC width in bits; legal range 9..24; high part is ADDR_W-8 bits.
- RESET_PC, 0: PC value after reset, ADDR_W bits.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- PCL_in  in  8  low-byte load data.
- PCH_in  in  ADDR_W-8  high-part load data.
- load  in  1  load PCL_in/PCH_in into PC.
- inc_enable  in  1  increment PC by 1.
- branch  in  1  start relative branch with offset.
- offset  in  8  two's-complement branch displacement, -128..+127.
- PCL_out  out  8  registered PC low byte.
- PCH_out  out  ADDR_W-8  registered PC high part.
- busy  out  1  high while in FIX state; strobes ignored.
- branch_done  out  1  one-cycle registered pulse when a branch completes.

## Operation
- States: IDLE, FIX. Reset state IDLE.
- Reset: PC <= RESET_PC; state <= IDLE; busy = 0; branch_done = 0. Reset overrides every strobe, in any state.
- In IDLE, one action per cycle. Priority is load > branch > inc_enable.
  - load: PC <= {PCH_in, PCL_in}.
  - branch:
    - Compute sum = {1'b0,PCL} + sign-extended offset (9-bit result). PCL <= sum[7:0].
    - Carry out of the low byte with offset >= 0, or borrow with offset < 0, is a page cross.
    - Page cross: latch direction (+1 or -1) and go to FIX.
    - No page cross: PCH unchanged, branch_done pulses next cycle, stay in IDLE.
  - inc_enable: PC <= PC + 1 as a full ADDR_W-bit add. Carry from PCL propagates into PCH in the same cycle. All-ones wraps to 0.
  - No strobe: hold.
- FIX:
  - PCH <= PCH + 1 or PCH - 1, modulo 2^(ADDR_W-8). PCL held.
  - Return to IDLE; branch_done pulses.
  - load, branch and inc_enable are ignored; the sequencer must not issue them while busy.
- Offset 0 behaves as a normal branch: completes in 1 cycle with no cross.
- The offset is relative to the current PC; operand-fetch increments are the sequencer's job.

## Timing
- All outputs are registers; they change only on the rising edge of clk.
- load and inc_enable: the new PC is visible on the edge they are sampled at. Latency 1.
- Branch without cross:
  - Final PC and branch_done = 1 in the cycle after the strobe edge.
  - branch_done returns to 0 on the following edge unless another branch completes.
- Branch with cross:
  - Edge 1: PCL updated, busy = 1, PCH still old.
  - Edge 2: PCH updated, busy = 0, branch_done = 1.
  - Total 2 cycles; the intermediate PC (old PCH, new PCL) is externally visible for one cycle, as on the 6502.
- Back-to-back branches in IDLE are allowed every cycle when no cross occurs.
- A strobe held high during FIX is sampled again only once state is IDLE.
- Reset asserted in FIX: next edge gives PC = RESET_PC, busy = 0, branch_done = 0. The pending fix-up is discarded.

## Test plan
- Reset, then reset=0 with no strobes: PC = 0x0000 (RESET_PC default), busy = 0, branch_done = 0, held for 3 cycles.
- Load 0xFE3F, then inc_enable for 3 cycles: PC 0xFE3F -> 0xFE40 -> 0xFE41 -> 0xFE42. With load and inc_enable both high, load wins: PC = 0xFE3F.
- PC = 0xFE42, branch with offset 0x10: next cycle PC = 0xFE52, branch_done = 1, busy never asserted.
- PC = 0xFEF0, branch with offset 0x20: cycle 1 PC = 0xFE10, busy = 1; cycle 2 PC = 0xFF10, busy = 0, branch_done = 1.
- Backward cross: PC = 0x0305, offset 0xF0 (-16): cycle 1 PC = 0x03F5, busy = 1; cycle 2 PC = 0x02F5.
- Wrap and reset cases:
  - PC = 0xFFFF with inc_enable: PC = 0x0000.
  - ADDR_W = 12 instance, PC = 0xFF0 with offset 0x7F (page cross): cycle 1 PC = 0xF6F, busy = 1; cycle 2 PCH wraps, PC = 0x06F.
  - Reset asserted during FIX: PC = RESET_PC and busy = 0 on the next edge.

Source files
------------

// File: rtl/branch_program_counter.sv
// 6502-style program counter: byte-split PC with load, increment and a two-phase
// relative branch whose high-part fix-up costs one extra cycle on a page cross.
module branch_program_counter #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        PCL_in,
  input  logic [ADDR_W-9:0] PCH_in,
  input  logic              load,
  input  logic              inc_enable,
  input  logic              branch,
  input  logic [7:0]        offset,
  output logic [7:0]        PCL_out,
  output logic [ADDR_W-9:0] PCH_out,
  output logic              busy,
  output logic              branch_done
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic {IDLE, FIX} state_t;

  state_t          state_q, state_d;
  logic [7:0]      pcl_q, pcl_d;
  logic [HI_W-1:0] pch_q, pch_d;
  logic            dir_up_q, dir_up_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [8:0]      br_sum;

  // 9-bit low-byte sum with the offset sign-extended into bit 8. Bit 8 set means
  // a carry for a forward branch or a borrow for a backward one.
  function automatic logic [8:0] low_byte_sum(input logic [7:0] pcl, input logic [7:0] off);
    return {1'b0, pcl} + {off[7], off};
  endfunction

  function automatic logic page_cross(input logic [8:0] sum);
    return sum[8];
  endfunction

  assign br_sum = low_byte_sum(pcl_q, offset);

  always_comb begin
    state_d  = state_q;
    pcl_d    = pcl_q;
    pch_d    = pch_q;
    dir_up_d = dir_up_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          pcl_d = PCL_in;
          pch_d = PCH_in;
        end else if (branch) begin
          pcl_d = br_sum[7:0];
          if (page_cross(br_sum)) begin
            dir_up_d = ~offset[7];
            busy_d   = 1'b1;
            state_d  = FIX;
          end else begin
            done_d = 1'b1;
          end
        end else if (inc_enable) begin
          {pch_d, pcl_d} = {pch_q, pcl_q} + ADDR_W'(1);
        end
      end
      FIX: begin
        pch_d   = dir_up_q ? pch_q + HI_W'(1) : pch_q - HI_W'(1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pcl_q    <= RESET_PC[7:0];
      pch_q    <= RESET_PC[ADDR_W-1:8];
      dir_up_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcl_q    <= pcl_d;
      pch_q    <= pch_d;
      dir_up_q <= dir_up_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign PCL_out     = pcl_q;
  assign PCH_out     = pch_q;
  assign busy        = busy_q;
  assign branch_done = done_q;

endmodule
